// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Optional signed-overflow flag is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] d_o,
    output logic             bout_o,
    output logic             ovf_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              br_q, br_d;
    logic              bout_q, bout_d;
    logic              diff_bit;
    logic              br_next;

    // The operand LSBs are always the bit under process since both registers shift right.
    assign diff_bit = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    br_d    = bin_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                d_d   = {diff_bit, d_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last edge a_q[0]/b_q[0] hold the operand sign bits.
                    ovf_d   = (a_q[0] ^ b_q[0]) & (diff_bit ^ a_q[0]);
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign d_o         = d_q;
    assign bout_o      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf_o       = ovf_q;
`else
    assign ovf_o       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): driver pushes expected results, a monitor
// pops and checks them on each rising out_valid, including the accept-to-valid latency.
module tb_serial_subtractor;

    localparam int unsigned W = 8;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        int unsigned  edge_no;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int unsigned n_total = 0;
    int unsigned n_pass = 0;
    logic        prev_valid = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .bin_i       (bin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .d_o         (d),
        .bout_o      (bout),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: one scoreboard pop per result presentation.
    always @(negedge clk) begin
        if (rst_n && out_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out_valid: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result_d", 64'(d), 64'(e.d));
                chk("result_bout", 64'(bout), 64'(e.bout));
                chk("result_ovf", 64'(ovf), 64'(e.ovf));
                chk("latency_edge", 64'(cyc), 64'(e.edge_no));
                chk("no_ready_with_valid", 64'(in_ready), 64'd0);
            end
        end
        prev_valid = out_valid;
    end

    // Present one operand pair; returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input bit expect_result);
        int unsigned guard;
        exp_t e;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready 0, expected 1 (cycle %0d)", cyc);
        end
        if (expect_result) begin
            e.d = ed; e.bout = eb; e.ovf = eo; e.edge_no = cyc + 1 + W;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'hC3; b = 8'h3C; bin = 1'b1;
    endtask

    task automatic drain();
        int unsigned guard;
        guard = 0;
        while ((sb_q.size() != 0 || !in_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_scoreboard_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int unsigned guard;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_d", 64'(d), 64'd0);
        chk("reset_bout", 64'(bout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);

        issue(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b1);
        drain();
        issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
        drain();
        issue(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        drain();
        issue(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: result held while new operands wait at the input.
        out_ready = 1'b0;
        issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, OvfEn, 1'b1);
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_reached_done", 64'(out_valid), 64'd1);
        a = 8'h7F; b = 8'hFF; bin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_d", 64'(d), 64'h7F);
            chk("bp_bout", 64'(bout), 64'd0);
            chk("bp_ovf", 64'(ovf), 64'(OvfEn));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        begin
            exp_t e;
            e.d = 8'h80; e.bout = 1'b1; e.ovf = OvfEn; e.edge_no = cyc + 1 + W;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Reset after bit 3 of an operation: its result must never appear.
        issue(8'h5A, 8'h23, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_d", 64'(d), 64'd0);
        chk("abort_bout", 64'(bout), 64'd0);
        repeat (12) @(negedge clk);
        chk("abort_still_idle", 64'(in_ready), 64'd1);
        issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor: the inverse-operation counterpart of the team's ripple-carry adder, built from the same full-cell structure with a borrow chain instead of a carry chain. It accepts one WIDTH-bit operand pair with a borrow-in over a valid/ready handshake. It resolves one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It returns the difference and borrow-out over a second valid/ready handshake. It is the area-cheap arithmetic option for datapaths that tolerate WIDTH-cycle latency.

## Interface
- WIDTH, 8: operand/result width in bits; legal range is 2 to 64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result held on d/bout/ovf.
- out_ready  in  1  downstream accepts result.
- d  out  WIDTH  difference, a - b - bin mod 2^WIDTH.
- bout  out  1  borrow-out; 1 iff a < b + bin (unsigned).
- ovf  out  1  signed overflow flag (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high at an edge, capture a, b and bin, clear the bit counter, and go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge processes bit i=cnt: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br).
  - Operand shift registers shift right. d_i enters the result register at the MSB and the register shifts right.
  - cnt increments. After the edge that processes bit WIDTH-1, latch bout = br_next and go to DONE.
- DONE:
  - out_valid=1; d, bout and ovf are stable.
  - An edge with out_ready=1 completes the transfer and returns the FSM to IDLE.
  - out_ready low holds DONE indefinitely with all outputs unchanged.
- in_valid is ignored outside IDLE. a, b and bin are don't-care after capture.
- The counter is $clog2(WIDTH)+1 bits wide and never wraps within an operation.
- Results are pure modular arithmetic: no saturation, no sign extension.

## Timing
- Reset (rst_n low at an edge) puts the FSM in IDLE and clears all registers.
- Outputs after reset: in_ready=1, out_valid=0, d=0, bout=0, ovf=0.
- While rst_n is held low, outputs reflect the post-reset values from the first reset edge onward.
- Reset asserted during RUN or DONE aborts the operation. The result is discarded and out_valid never pulses for it.
- Latency:
  - out_valid rises exactly WIDTH edges after the accepting edge. With WIDTH=8, accept at edge E0 gives out_valid high after E8.
  - The earliest next accept is the edge after DONE exits, so minimum issue interval is WIDTH+2 cycles.
- in_ready and out_valid decode directly from state registers, with no combinational path from inputs.
- in_ready and out_valid are never high in the same cycle.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - In the final RUN edge, register ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (d[WIDTH-1] ^ a[WIDTH-1]).
  - ovf is valid with out_valid and cleared on reset.
- SERIAL_SUB_OVF_EN undefined:
  - ovf is tied to 0, no overflow logic is synthesized, and the operand MSB is not retained for it.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- a=0x5A, b=0x23, bin=0 -> d=0x37, bout=0, ovf=0; out_valid 8 edges after accept.
- a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0; ovf=1 with SERIAL_SUB_OVF_EN, ovf=0 without.
- a=0x10, b=0x10, bin=1 -> d=0xFF, bout=1; then a=0xFF, b=0x00, bin=1 -> d=0xFE, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - Required: d/bout/ovf stable, in_ready=0, new operands not captured.
  - On release, in_ready=1 the next cycle and the new pair is then accepted.
- Reset mid-op: drop rst_n for one edge after bit 3 of a=0x5A, b=0x23.
  - Required: out_valid never asserts, in_ready=1 and d=0 after reset.
  - A following a=0x05, b=0x03 must yield d=0x02, bout=0.
